// File: rtl/camlink_axis_tap_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : camlink_axis_tap_packer
// Brief    : Packs parsed CameraLink taps into a frame-aligned AXI4-Stream
//            video stream through a FWFT FIFO, drops to the next frame on
//            overflow, and reports per-frame line/length diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module camlink_axis_tap_packer #(
    parameter int TAP_WIDTH  = 8,
    parameter int NUM_TAPS   = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int USE_DVAL   = 1
) (
    input  logic                          axis_clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          cam_dval,
    input  logic                          cam_lval,
    input  logic                          cam_fval,
    input  logic [NUM_TAPS*TAP_WIDTH-1:0] cam_data,
    output logic [NUM_TAPS*TAP_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic [CNT_WIDTH-1:0]          line_length,
    output logic [CNT_WIDTH-1:0]          line_count,
    output logic                          frame_error
);

    localparam int                   DW         = NUM_TAPS * TAP_WIDTH;
    localparam int                   AW         = $clog2(FIFO_DEPTH);
    localparam int                   EW         = DW + 2;
    localparam logic [AW:0]          C_FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic                 C_USE_DVAL = (USE_DVAL != 0);
    localparam logic [CNT_WIDTH-1:0] C_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_STREAM     = 2'd2,
        S_DROP       = 2'd3
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + C_ONE;
    endfunction

    // ------------------------------------------------------------------ input stage
    logic          dval_q, lval_q, fval_q, lval_p_q, fval_p_q;
    logic [DW-1:0] data_q;

    // Register the timing bits and keep their previous value for edge detection.
    // FVAL history resets high so a frame already in progress at reset release
    // never looks like a rising edge; capture waits for a genuine new frame.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            dval_q   <= 1'b0;
            lval_q   <= 1'b0;
            fval_q   <= 1'b1;
            lval_p_q <= 1'b0;
            fval_p_q <= 1'b1;
            data_q   <= '0;
        end else begin
            dval_q   <= cam_dval;
            lval_q   <= cam_lval;
            fval_q   <= cam_fval;
            lval_p_q <= lval_q;
            fval_p_q <= fval_q;
            data_q   <= cam_data;
        end
    end

    logic w_fval_rise, w_fval_fall, w_lval_fall, w_beat;
    assign w_fval_rise = fval_q & ~fval_p_q;
    assign w_fval_fall = ~fval_q & fval_p_q;
    assign w_lval_fall = ~lval_q & lval_p_q;
    assign w_beat      = fval_q & lval_q & (dval_q | ~C_USE_DVAL);

    // ------------------------------------------------------------------ control FSM
    state_t state_q, state_d;
    logic   w_start, w_capture;
    logic   w_push_req, w_push_last, w_push_ok, w_drop, w_pop, w_full;
    logic   pend_vld_q, pend_vld_d, sof_q, sof_d;
    logic [DW-1:0] pend_data_q, pend_data_d;

    // The beat present on the frame's first cycle is captured on the same edge
    // that enters STREAM, so no pixel of a frame-aligned line is lost.
    assign w_start     = (state_q == S_WAIT_FRAME) & enable & w_fval_rise;
    assign w_capture   = (state_q == S_STREAM) | w_start;
    assign w_push_last = w_lval_fall | w_fval_fall;
    assign w_push_req  = (state_q == S_STREAM) & pend_vld_q & (w_beat | w_push_last);
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & ~w_push_ok;

    // State register.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a frame end always wins over an overflow in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (enable) state_d = S_WAIT_FRAME;
            S_WAIT_FRAME: if (!enable) state_d = S_IDLE;
                          else if (w_fval_rise) state_d = S_STREAM;
            S_STREAM:     if (w_fval_fall) state_d = S_WAIT_FRAME;
                          else if (w_drop) state_d = S_DROP;
            S_DROP:       if (w_fval_fall) state_d = S_WAIT_FRAME;
            default:      state_d = S_IDLE;
        endcase
    end

    // Pending beat: held until the next beat or a line/frame end tells us its TLAST.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        sof_d       = sof_q;
        if (w_start)        sof_d = 1'b1;
        else if (w_push_ok) sof_d = 1'b0;
        if (!w_capture || w_drop) begin
            pend_vld_d = 1'b0;
        end else begin
            if (w_push_ok) pend_vld_d = 1'b0;
            if (w_beat) begin
                pend_vld_d  = 1'b1;
                pend_data_d = data_q;
            end
        end
    end

    // Pending register update.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            sof_q       <= 1'b0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            sof_q       <= sof_d;
        end
    end

    // ------------------------------------------------------------------ FWFT FIFO
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [EW-1:0] w_head;
    logic          w_tvalid;

    assign w_tvalid = (count_q != '0);
    assign w_full   = (count_q == C_FULL);
    assign w_pop    = w_tvalid & m_axis_tready;
    assign w_head   = mem_q[rd_ptr_q];

    // Storage array; entry = {tuser, tlast, tdata}.
    always_ff @(posedge axis_clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= {sof_q, w_push_last, pend_data_q};
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_push_ok && !w_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!w_push_ok && w_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // The head is masked while empty so stale storage never appears on the bus.
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_tvalid ? w_head[DW-1:0] : '0;
    assign m_axis_tlast  = w_tvalid & w_head[DW];
    assign m_axis_tuser  = w_tvalid & w_head[DW+1];

    // ------------------------------------------------------------------ diagnostics
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, line_len_q, line_len_d;
    logic [CNT_WIDTH-1:0] ref_len_q, ref_len_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] line_count_q, line_count_d, drop_count_q, drop_count_d;
    logic [CNT_WIDTH-1:0] w_len;
    logic                 ref_vld_q, ref_vld_d, mis_seen_q, mis_seen_d;
    logic                 overflow_q, overflow_d, frame_error_q, frame_error_d;
    logic                 w_mismatch;

    assign w_len = sat_inc(beat_cnt_q);

    // Line length, line count, reference-length compare and overflow accounting.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        line_len_d   = line_len_q;
        ref_len_d    = ref_len_q;
        ref_vld_d    = ref_vld_q;
        mis_seen_d   = mis_seen_q;
        line_cnt_d   = line_cnt_q;
        line_count_d = line_count_q;
        overflow_d   = overflow_q | w_drop;
        drop_count_d = w_drop ? sat_inc(drop_count_q) : drop_count_q;
        w_mismatch   = 1'b0;
        if (w_start) begin
            beat_cnt_d = '0;
            line_cnt_d = '0;
            ref_vld_d  = 1'b0;
            mis_seen_d = 1'b0;
        end else if (w_push_ok) begin
            if (w_push_last) begin
                beat_cnt_d = '0;
                line_len_d = w_len;
                line_cnt_d = sat_inc(line_cnt_q);
                if (!ref_vld_q) begin
                    ref_vld_d = 1'b1;
                    ref_len_d = w_len;
                end else if ((w_len != ref_len_q) && !mis_seen_q) begin
                    w_mismatch = 1'b1;
                    mis_seen_d = 1'b1;
                end
            end else begin
                beat_cnt_d = w_len;
            end
        end
        // The final line's TLAST push can coincide with the frame end.
        if ((state_q == S_STREAM) && w_fval_fall)
            line_count_d = (w_push_ok && w_push_last) ? sat_inc(line_cnt_q) : line_cnt_q;
        frame_error_d = w_drop | w_mismatch;
    end

    // Diagnostic registers.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q    <= '0;
            line_len_q    <= '0;
            ref_len_q     <= '0;
            ref_vld_q     <= 1'b0;
            mis_seen_q    <= 1'b0;
            line_cnt_q    <= '0;
            line_count_q  <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            beat_cnt_q    <= beat_cnt_d;
            line_len_q    <= line_len_d;
            ref_len_q     <= ref_len_d;
            ref_vld_q     <= ref_vld_d;
            mis_seen_q    <= mis_seen_d;
            line_cnt_q    <= line_cnt_d;
            line_count_q  <= line_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign line_length = line_len_q;
    assign line_count  = line_count_q;
    assign frame_error = frame_error_q;

endmodule
`default_nettype wire
